digit_buffer_echo: RTL and testbench
====================================

Name: digit_buffer_echo

Overview:
Parametrised successor of the UART digit-entry buffer in the calculator front end. It collects ASCII decimal digits from an already-deframed receive byte stream into a DEPTH-digit shift buffer, with clear and backspace editing. On submit it snapshots the buffer and transmits only the entered digits back as ASCII through a byte-level transmitter handshake. It also drives a WINDOW-digit scrolling display view of the snapshot. It sits between the UART RX/TX byte cores and the seven-segment display driver.

Parameters:
DEPTH, 8, buffer depth in digits; at least 2.
WINDOW, 4, digits shown on the display; 1 ≤ WINDOW ≤ DEPTH.
CW, $clog2(DEPTH+1), width of the count output; derived, never overridden.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte; valid only while rx_valid is high
rx_valid  in  1  one-cycle pulse per received byte
clear  in  1  level input; rising edge clears the live buffer
submit  in  1  level input; rising edge starts snapshot and echo
scroll_tick  in  1  one-cycle pulse that advances the display window
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle byte-send request
tx_data  out  8  byte to send; held stable from the tx_start cycle until the next byte
n  out  CW  digit count captured at the last submit
win_digits  out  4*WINDOW  display digits; leftmost digit in the MSB nibble
overflow  out  1  sticky; set when an accepted digit drops the oldest digit
echo_busy  out  1  high while the echo sequence runs

Behaviour:
- Reset: all outputs, live buffer, snapshot, count, window position and edge-detect registers are 0. The FSM enters IDLE.
- Live buffer: entries mem[0..DEPTH-1], with mem[DEPTH-1] the newest. cnt ranges 0..DEPTH.
- Digit (rx_valid and rx_data in 0x30..0x39):
  - Shift toward index 0; mem[DEPTH-1] takes rx_data[3:0].
  - cnt increments and saturates at DEPTH.
  - If cnt was already DEPTH, the oldest digit is lost and overflow is set to 1.
- Backspace (rx_valid and rx_data equal to 0x08 or 0x7F):
  - If cnt > 0: shift toward index DEPTH-1, mem[0] becomes 0, cnt decrements.
  - If cnt = 0: no effect.
- Any other byte: ignored.
- Clear rising edge: mem, cnt and overflow go to 0.
- Same cycle: clear edge beats rx_valid, and the received byte is dropped.
- Submit rising edge while in IDLE:
  - snap takes mem, n takes cnt, window position becomes 0, FSM goes to LOAD.
  - A submit edge outside IDLE is ignored.
- During echo, the live buffer keeps accepting rx, clear and backspace. The snapshot is frozen.
- Echo FSM:
  - IDLE: no action.
  - LOAD: idx becomes DEPTH-cnt_snap. If n = 0, go to DONE; otherwise go to SEND.
  - SEND: wait for tx_busy = 0. Then pulse tx_start for exactly one cycle with tx_data = {4'h3, snap[idx]}, and go to GAP.
  - GAP: one cycle, which absorbs the transmitter's busy-assert latency. Go to WAIT.
  - WAIT: on tx_busy = 0, if idx = DEPTH-1 go to DONE; otherwise increment idx and go to SEND.
  - DONE: return to IDLE.
  - echo_busy is high in every state except IDLE.
  - tx_data is 0 in IDLE.
- Display:
  - maxpos = (n > WINDOW) ? n-WINDOW : 0.
  - base = DEPTH - max(n, WINDOW) + pos.
  - win_digits is registered: snap[base .. base+WINDOW-1], updated every cycle.
  - Count below WINDOW: leading positions show zeros from the snapshot, so the digits are right-aligned.
  - On scroll_tick: pos increments; at pos = maxpos it wraps to 0.
  - A submit edge in the same cycle as scroll_tick wins, and pos becomes 0.
- Reset asserted mid-echo: tx_start deasserts immediately and the remainder of the echo is abandoned.

Optional Feature:
TX_CRLF_EN.
- Defined: after the last digit, or directly from LOAD when n = 0, the FSM sends 0x0D then 0x0A. It uses the same SEND/GAP/WAIT handshake before going to DONE.
- Undefined: only the digits are sent, and n = 0 produces no transmission.

Decomposition:
- Shared package (calc_pkg) holds:
  - the ASCII constants: digit base 0x30, BS 0x08, DEL 0x7F, CR, LF;
  - the echo state enum: IDLE, LOAD, SEND, GAP, WAIT, DONE, CR, LF.
- One natural sub-module: rise_detect, used twice for clear and submit.
- The echo FSM and display window stay inline.

Test Plan:
- Receive "1","2","3", then submit with tx_busy modelled (high 10 cycles after each start) → exactly 3 starts with tx_data 0x31, 0x32, 0x33. n = 3. win_digits = 0x0123 (DEPTH=8, WINDOW=4).
- Receive nine digits "123456789" → overflow = 1 and cnt = 8. Submit → echo is "23456789".
- Receive "45", then 0x08, then "7", then submit → echo is "47". Then 0x08 ×3 with cnt = 0 → no underflow, cnt stays 0.
- Receive 6 digits "123456", submit, then 3 scroll_ticks → win_digits sequence 1234 → 2345 → 3456 → 1234 (wrap).
- Clear edge in the same cycle as rx_valid of "5" → cnt = 0 and the digit is dropped. Submit edge during echo → ignored, and no extra bytes are sent.
- With TX_CRLF_EN, submit with n = 0 → bytes 0x0D, 0x0A only. Reset asserted mid-echo → tx_start = 0, echo_busy = 0, n = 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared ASCII constants, echo FSM states and byte classifiers for the calculator front end.
package calc_pkg;

   localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
   localparam logic [7:0] ASCII_DIGIT_LAST = 8'h39;
   localparam logic [7:0] ASCII_BS         = 8'h08;
   localparam logic [7:0] ASCII_DEL        = 8'h7F;
   localparam logic [7:0] ASCII_CR         = 8'h0D;
   localparam logic [7:0] ASCII_LF         = 8'h0A;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      GAP,
      WAIT,
      DONE,
      CR,
      LF
   } echo_state_t;

   typedef enum logic [1:0] {
      SEL_DIGIT,
      SEL_CR,
      SEL_LF
   } byte_sel_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_DIGIT_BASE) && (b <= ASCII_DIGIT_LAST);
   endfunction

   function automatic logic is_backspace(input logic [7:0] b);
      return (b == ASCII_BS) || (b == ASCII_DEL);
   endfunction

endpackage

// File: rtl/digit_buffer_echo_rise_detect.sv
// Rising-edge detector for a synchronous level input; o_rise is high for the first cycle the level is seen high.
module rise_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_prev <= 1'b0;
      else          r_prev <= i_level;
   end

   assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/digit_buffer_echo.sv
// Digit-entry buffer with clear/backspace editing, submit-time snapshot, ASCII echo and scrolling display window.
// Build option: define TX_CRLF_EN to append CR LF after every echo (also sent when the snapshot is empty).
module digit_buffer_echo
   import calc_pkg::*;
#(
   parameter  int DEPTH  = 8,
   parameter  int WINDOW = 4,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic                clear,
   input  logic                submit,
   input  logic                scroll_tick,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   output logic [CW-1:0]       n,
   output logic [4*WINDOW-1:0] win_digits,
   output logic                overflow,
   output logic                echo_busy
);

   localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]   WINDOW_C = CW'(WINDOW);
   localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 1);

   logic [3:0]          r_mem  [DEPTH];
   logic [3:0]          r_snap [DEPTH];
   logic [CW-1:0]       r_cnt;
   logic                r_overflow;
   logic [CW-1:0]       r_n;
   logic [CW-1:0]       r_pos;
   logic [4*WINDOW-1:0] r_win;
   logic [IW-1:0]       r_idx;
   byte_sel_t           r_sel;
   logic [7:0]          r_tx_hold;
   echo_state_t         r_state;
   echo_state_t         w_state_nxt;

   logic                w_clear_rise;
   logic                w_submit_rise;
   logic                w_submit_go;
   logic                w_is_digit;
   logic                w_is_bs;
   logic                w_tx_start;
   logic [7:0]          w_tx_byte;
   logic [CW-1:0]       w_maxpos;
   logic [CW-1:0]       w_span;
   logic [CW-1:0]       w_base;
   logic [IW-1:0]       w_sel;
   logic [4*WINDOW-1:0] w_win;

   rise_detect u_clear_rise (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_level (clear),
      .o_rise  (w_clear_rise)
   );

   rise_detect u_submit_rise (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_level (submit),
      .o_rise  (w_submit_rise)
   );

   assign w_is_digit  = rx_valid && is_digit(rx_data);
   assign w_is_bs     = rx_valid && is_backspace(rx_data);
   assign w_submit_go = w_submit_rise && (r_state == IDLE);

   // Live buffer: clear edge has priority and drops a same-cycle received byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else if (w_clear_rise) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else if (w_is_digit) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
         r_mem[DEPTH-1] <= rx_data[3:0];
         if (r_cnt == DEPTH_C) r_overflow <= 1'b1;
         else                  r_cnt      <= r_cnt + 1'b1;
      end else if (w_is_bs && (r_cnt != '0)) begin
         for (int unsigned i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
         r_mem[0] <= '0;
         r_cnt    <= r_cnt - 1'b1;
      end
   end

   always_comb begin
      w_maxpos = (r_n > WINDOW_C) ? (r_n - WINDOW_C) : '0;
      w_span   = (r_n > WINDOW_C) ? r_n : WINDOW_C;
      w_base   = DEPTH_C - w_span + r_pos;
      w_sel    = '0;
      w_win    = '0;
      for (int unsigned j = 0; j < WINDOW; j++) begin
         w_sel = IW'(w_base + CW'(j));
         w_win[4*(WINDOW-1-j) +: 4] = r_snap[w_sel];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_snap[i] <= '0;
         r_n   <= '0;
         r_pos <= '0;
         r_win <= '0;
      end else begin
         r_win <= w_win;
         if (w_submit_go) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_snap[i] <= r_mem[i];
            r_n   <= r_cnt;
            r_pos <= '0;
         end else if (scroll_tick) begin
            r_pos <= (r_pos >= w_maxpos) ? '0 : r_pos + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_start  = 1'b0;
      case (r_state)
         IDLE: if (w_submit_go) w_state_nxt = LOAD;
         LOAD: begin
            if (r_n == '0) begin
`ifdef TX_CRLF_EN
               w_state_nxt = CR;
`else
               w_state_nxt = DONE;
`endif
            end else begin
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               w_tx_start  = 1'b1;
               w_state_nxt = GAP;
            end
         end
         GAP:  w_state_nxt = WAIT;
         WAIT: begin
            if (!tx_busy) begin
               case (r_sel)
                  SEL_DIGIT: begin
                     if (r_idx == LAST_IDX) begin
`ifdef TX_CRLF_EN
                        w_state_nxt = CR;
`else
                        w_state_nxt = DONE;
`endif
                     end else begin
                        w_state_nxt = SEND;
                     end
                  end
                  SEL_CR:  w_state_nxt = LF;
                  default: w_state_nxt = DONE;
               endcase
            end
         end
         DONE:    w_state_nxt = IDLE;
         CR, LF:  w_state_nxt = SEND;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      case (r_sel)
         SEL_DIGIT: w_tx_byte = {ASCII_DIGIT_BASE[7:4], r_snap[r_idx]};
         SEL_CR:    w_tx_byte = ASCII_CR;
         default:   w_tx_byte = ASCII_LF;
      endcase
   end

   // r_tx_hold keeps the last byte on tx_data between starts and reads 0 whenever the FSM is idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx     <= '0;
         r_sel     <= SEL_DIGIT;
         r_tx_hold <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_idx <= IW'(DEPTH_C - r_n);
               r_sel <= SEL_DIGIT;
            end
            WAIT: begin
               if (!tx_busy && (r_sel == SEL_DIGIT) && (r_idx != LAST_IDX))
                  r_idx <= r_idx + 1'b1;
            end
            CR:      r_sel <= SEL_CR;
            LF:      r_sel <= SEL_LF;
            default: ;
         endcase
         if (w_state_nxt == IDLE) r_tx_hold <= '0;
         else if (w_tx_start)     r_tx_hold <= w_tx_byte;
      end
   end

   assign tx_start   = w_tx_start;
   assign tx_data    = w_tx_start ? w_tx_byte : r_tx_hold;
   assign n          = r_n;
   assign win_digits = r_win;
   assign overflow   = r_overflow;
   assign echo_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_digit_buffer_echo.sv
// Directed bench for digit_buffer_echo (DEPTH=8, WINDOW=4) with a busy-for-10-cycles transmitter model.
module tb_digit_buffer_echo;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        clear = 1'b0;
   logic        submit = 1'b0;
   logic        scroll_tick = 1'b0;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [3:0]  n_out;
   logic [15:0] win_digits;
   logic        overflow;
   logic        echo_busy;

   int          n_checks = 0;
   int          n_fail = 0;
   int          busy_cnt = 0;
   int          dbl_start = 0;
   logic        prev_start = 1'b0;
   logic [7:0]  tx_q[$];
   int          q_snap;

   always #5 clk = ~clk;

   digit_buffer_echo #(.DEPTH(8), .WINDOW(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .clear       (clear),
      .submit      (submit),
      .scroll_tick (scroll_tick),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .n           (n_out),
      .win_digits  (win_digits),
      .overflow    (overflow),
      .echo_busy   (echo_busy)
   );

   always @(posedge clk or negedge reset) begin
      if (!reset)             busy_cnt <= 0;
      else if (tx_start)      busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   always @(posedge clk) begin
      if (tx_start) tx_q.push_back(tx_data);
      if (tx_start && prev_start) dbl_start++;
      prev_start = tx_start;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic pulse_submit();
      @(negedge clk);
      submit = 1'b1;
      @(negedge clk);
      submit = 1'b0;
   endtask

   task automatic pulse_scroll();
      @(negedge clk);
      scroll_tick = 1'b1;
      @(negedge clk);
      scroll_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_echo_done();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (echo_busy && k < 2000);
      chk("echo_done", echo_busy, 1'b0);
   endtask

   task automatic check_echo(input string tag, input string s);
      string e;
`ifdef TX_CRLF_EN
      e = {s, "\r\n"};
`else
      e = s;
`endif
      chk({tag, "_len"}, tx_q.size(), e.len());
      for (int i = 0; i < e.len() && i < tx_q.size(); i++) chk(tag, tx_q[i], e[i]);
      tx_q.delete();
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_n", n_out, 4'd0);
      chk("rst_win", win_digits, 16'h0000);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_echo_busy", echo_busy, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // basic echo of "123"
      send_str("123");
      pulse_submit();
      wait_echo_done();
      check_echo("echo_123", "123");
      chk("n_123", n_out, 4'd3);
      chk("win_123", win_digits, 16'h0123);
      chk("idle_tx_data", tx_data, 8'h00);
      chk("ovf_123", overflow, 1'b0);

      // overflow boundary
      pulse_clear();
      send_str("12345678");
      chk("ovf_at_depth", overflow, 1'b0);
      send_str("9");
      chk("ovf_set", overflow, 1'b1);
      pulse_submit();
      wait_echo_done();
      check_echo("echo_ovf", "23456789");
      chk("n_ovf", n_out, 4'd8);
      chk("win_ovf", win_digits, 16'h2345);
      pulse_clear();
      chk("ovf_cleared", overflow, 1'b0);

      // backspace editing and underflow guard
      send_str("45");
      send_byte(8'h08);
      send_str("7");
      pulse_submit();
      wait_echo_done();
      check_echo("echo_bs", "47");
      chk("n_bs", n_out, 4'd2);
      chk("win_bs", win_digits, 16'h0047);
      pulse_clear();
      send_byte(8'h08);
      send_byte(8'h08);
      send_byte(8'h08);
      send_str("A");
      pulse_submit();
      wait_echo_done();
      check_echo("echo_empty", "");
      chk("n_underflow", n_out, 4'd0);
      send_str("5");
      pulse_submit();
      wait_echo_done();
      check_echo("echo_after_uf", "5");
      chk("n_after_uf", n_out, 4'd1);
      send_byte(8'h7F);
      pulse_submit();
      wait_echo_done();
      check_echo("echo_del", "");
      chk("n_del", n_out, 4'd0);

      // scrolling window with wrap
      pulse_clear();
      send_str("123456");
      pulse_submit();
      wait_echo_done();
      check_echo("echo_scroll", "123456");
      chk("win_pos0", win_digits, 16'h1234);
      pulse_scroll();
      chk("win_pos1", win_digits, 16'h2345);
      pulse_scroll();
      chk("win_pos2", win_digits, 16'h3456);
      pulse_scroll();
      chk("win_wrap", win_digits, 16'h1234);

      // submit beats same-cycle scroll
      pulse_scroll();
      chk("win_pre_tie", win_digits, 16'h2345);
      @(negedge clk);
      submit      = 1'b1;
      scroll_tick = 1'b1;
      @(negedge clk);
      submit      = 1'b0;
      scroll_tick = 1'b0;
      wait_echo_done();
      check_echo("echo_tie", "123456");
      chk("win_tie", win_digits, 16'h1234);

      // clear edge drops a same-cycle digit
      @(negedge clk);
      clear    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h35;
      @(negedge clk);
      clear    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      pulse_submit();
      wait_echo_done();
      check_echo("echo_clr_tie", "");
      chk("n_clr_tie", n_out, 4'd0);
      send_str("7");
      pulse_submit();
      wait_echo_done();
      check_echo("echo_clr_drop", "7");

      // submit edge during echo ignored
      pulse_clear();
      send_str("12");
      pulse_submit();
      repeat (5) @(negedge clk);
      chk("busy_mid_echo", echo_busy, 1'b1);
      pulse_submit();
      wait_echo_done();
      repeat (30) @(negedge clk);
      chk("no_restart", echo_busy, 1'b0);
      check_echo("echo_resubmit", "12");
      chk("n_resubmit", n_out, 4'd2);
      chk("single_cycle_start", dbl_start, 0);

      // reset mid-echo
      pulse_clear();
      send_str("1234");
      pulse_submit();
      begin
         int k;
         k = 0;
         while (tx_q.size() < 2 && k < 500) begin
            @(negedge clk);
            k++;
         end
         chk("mid_echo_reached", (tx_q.size() >= 2), 1'b1);
      end
      reset = 1'b0;
      #1;
      chk("rst_mid_tx_start", tx_start, 1'b0);
      chk("rst_mid_busy", echo_busy, 1'b0);
      chk("rst_mid_n", n_out, 4'd0);
      chk("rst_mid_tx_data", tx_data, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      q_snap = tx_q.size();
      repeat (50) @(negedge clk);
      chk("rst_mid_abandon", tx_q.size(), q_snap);
      chk("rst_mid_idle", echo_busy, 1'b0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
